// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch stage: FSM states, word width, queue entry layout.
package fetch_pkg;

   localparam int WORD = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   typedef struct packed {
      logic [15:0]     pc;
      logic [WORD-1:0] word;
   } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with flush (flush beats push and pop).
// Latency: pushed entry at head the next cycle; backpressure: push ignored when full, pop ignored when empty.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [W-1:0]           i_din,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output logic [W-1:0]           o_dout,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [PW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == (PW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (!reset || i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // Storage needs no reset: an empty queue never exposes it.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr] <= i_din;
   end

endmodule

// File: rtl/insn_prefetch.sv
// insn_prefetch: single-outstanding fetch FSM feeding a {pc,word} queue; FETCH_BYPASS_EN adds an ack-cycle bypass to out_*.
// Latency: word visible the cycle after its ack (same cycle with bypass); backpressure: a full queue stops new requests.
module insn_prefetch
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 16,
   parameter int DW    = WORD
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          halt,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_pc,
   input  logic          out_ready
);
   localparam int CW = $clog2(DEPTH) + 1;

   state_t           r_state;
   logic [AW-1:0]    r_fpc;
   logic [AW-1:0]    r_addr;
   logic             w_ack_req;
   logic             w_byp;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_room;
   logic [CW-1:0]    w_count;
   logic [CW-1:0]    w_count_after;
   logic [AW+DW-1:0] w_head;

   assign mem_req   = (r_state != ST_IDLE);
   assign mem_addr  = r_addr;
   assign w_ack_req = (r_state == ST_REQ) && mem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
   assign w_byp     = w_empty && w_ack_req;
   assign out_valid = !w_empty || w_byp;
   assign out_data  = w_empty ? (w_byp ? mem_data : '0) : w_head[DW-1:0];
   assign out_pc    = w_empty ? (w_byp ? r_addr : '0) : w_head[AW+DW-1:DW];
`else
   assign w_byp     = 1'b0;
   assign out_valid = !w_empty;
   assign out_data  = w_empty ? '0 : w_head[DW-1:0];
   assign out_pc    = w_empty ? '0 : w_head[AW+DW-1:DW];
`endif

   assign w_pop  = !w_empty && out_ready && !redirect;
   assign w_push = w_ack_req && !(w_byp && out_ready);
   // Room after this ack's enqueue, crediting a same-cycle pop.
   assign w_count_after = w_count - CW'(w_pop);
   assign w_room        = (w_count_after < CW'(DEPTH - 1));

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (AW + DW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   ({r_addr, mem_data}),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .o_dout  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_fpc   <= '0;
         r_addr  <= '0;
      end else begin
         if (redirect) r_fpc <= redirect_pc;
         case (r_state)
            ST_IDLE: begin
               if (!redirect && !halt && !w_full) begin
                  r_state <= ST_REQ;
                  r_addr  <= r_fpc;
               end
            end
            ST_REQ: begin
               if (mem_ack && redirect) begin
                  r_addr  <= redirect_pc;
                  r_state <= halt ? ST_IDLE : ST_REQ;
               end else if (mem_ack) begin
                  r_fpc  <= r_fpc + 1'b1;
                  r_addr <= r_fpc + 1'b1;
                  if (!w_room || halt) r_state <= ST_IDLE;
               end else if (redirect) begin
                  // The old request must still complete; its word is dropped in DROP.
                  r_state <= ST_DROP;
               end
            end
            ST_DROP: begin
               if (mem_ack) begin
                  r_addr  <= redirect ? redirect_pc : r_fpc;
                  r_state <= halt ? ST_IDLE : ST_REQ;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_insn_prefetch.sv
// Bench for insn_prefetch: directed scenarios plus a random soak, every cycle checked against a queue-based model.
module tb_insn_prefetch;
   import fetch_pkg::*;

   localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        halt;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic        out_valid;
   logic [15:0] out_data;
   logic [15:0] out_pc;
   logic        out_ready;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one outstanding read (m_req/m_addr), a flag for a
   // read whose data must be thrown away, the fetch pointer, and the queue.
   bit          m_req;
   bit          m_stale;
   logic [15:0] m_addr;
   logic [15:0] m_fpc;
   entry_t      m_q[$];

   insn_prefetch #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .halt        (halt),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_data    (mem_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_pc      (out_pc),
      .out_ready   (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_req   = 1'b0;
      m_stale = 1'b0;
      m_addr  = '0;
      m_fpc   = '0;
      m_q.delete();
   endtask

   // Advance the model by one clock edge using the inputs of the cycle just ended.
   task automatic model_update();
      int     n0;
      bit     pop;
      entry_t e;
      n0  = m_q.size();
      pop = (n0 > 0) && out_ready && !redirect;
      if (!reset) begin
         model_reset();
      end else if (redirect) begin
         m_q.delete();
         m_fpc = redirect_pc;
         if (m_req && mem_ack) begin
            m_stale = 1'b0;
            m_req   = !halt;
            m_addr  = redirect_pc;
         end else if (m_req) begin
            m_stale = 1'b1;
         end
      end else begin
         if (pop) void'(m_q.pop_front());
         if (!m_req) begin
            if (!halt && n0 < DEPTH) begin
               m_req  = 1'b1;
               m_addr = m_fpc;
            end
         end else if (mem_ack) begin
            if (m_stale) begin
               m_stale = 1'b0;
               m_req   = !halt;
               m_addr  = m_fpc;
            end else begin
               if (!(BYP && n0 == 0 && out_ready)) begin
                  e.pc   = m_addr;
                  e.word = mem_data;
                  m_q.push_back(e);
               end
               m_fpc  = m_fpc + 16'd1;
               m_req  = !halt && (m_q.size() < DEPTH);
               m_addr = m_fpc;
            end
         end
      end
   endtask

   // One clock cycle: drive inputs, check outputs at the falling edge, then advance the model.
   task automatic step(input bit rst_i, input bit hlt_i, input bit rdr_i,
                       input logic [15:0] rpc_i, input int ack_pct, input int rdy_pct);
      bit          e_vld;
      logic [15:0] e_pc;
      logic [15:0] e_dat;
      reset       = rst_i;
      halt        = hlt_i;
      redirect    = rdr_i;
      redirect_pc = rpc_i;
      out_ready   = ($urandom_range(99) < rdy_pct);
      if (m_req) mem_ack = ($urandom_range(99) < ack_pct);
      else       mem_ack = (ack_pct > 0) && ($urandom_range(99) < 3);
      mem_data    = 16'($urandom);
      @(negedge clk);
      e_vld = (m_q.size() > 0) ||
              (BYP && m_req && !m_stale && mem_ack && !redirect);
      check("mem_req", 32'(mem_req), 32'(m_req));
      if (m_req) check("mem_addr", 32'(mem_addr), 32'(m_addr));
      check("out_valid", 32'(out_valid), 32'(e_vld));
      if (e_vld) begin
         if (m_q.size() > 0) begin
            e_pc  = m_q[0].pc;
            e_dat = m_q[0].word;
         end else begin
            e_pc  = m_addr;
            e_dat = mem_data;
         end
         check("out_pc", 32'(out_pc), 32'(e_pc));
         check("out_data", 32'(out_data), 32'(e_dat));
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic logic [15:0] pick_pc();
      logic [15:0] pc;
      case ($urandom_range(3))
         0:       pc = 16'h0040;
         1:       pc = 16'hFFFE;
         2:       pc = 16'hFFFF;
         default: pc = 16'($urandom);
      endcase
      return pc;
   endfunction

   initial begin
      reset       = 1'b0;
      halt        = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      mem_ack     = 1'b0;
      mem_data    = '0;
      out_ready   = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_pc", 32'(out_pc), 32'd0);
      step(1'b0, 1'b0, 1'b0, 16'h0, 0, 100);

      // Streaming: ack every cycle, consumer always ready.
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 100, 100);
      // Fill with consumer stalled, then a single pop.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 100, 0);
      step(1'b1, 1'b0, 1'b0, 16'h0, 100, 100);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 100, 0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 100, 100);
      // Redirect to 0x0040 with the outstanding ack held off for 3 cycles.
      step(1'b1, 1'b0, 1'b1, 16'h0040, 0, 100);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 0, 100);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 100, 100);
      // Redirect coinciding with an ack.
      step(1'b1, 1'b0, 1'b1, 16'h0100, 100, 100);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 100, 100);
      // Halt with a request outstanding, ack arrives under halt, then resume.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0, 0, 100);
      step(1'b1, 1'b1, 1'b0, 16'h0, 100, 100);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'h0, 100, 100);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 100, 100);
      // Address wrap.
      step(1'b1, 1'b0, 1'b1, 16'hFFFE, 100, 100);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 100, 100);
      // Reset in the middle of a request.
      step(1'b1, 1'b0, 1'b0, 16'h0, 0, 100);
      step(1'b0, 1'b0, 1'b0, 16'h0, 0, 100);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 100, 100);

      // Random soak.
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(499) != 0,
              $urandom_range(99) < 15,
              $urandom_range(99) < 6,
              pick_pc(),
              30 + int'($urandom_range(70)),
              int'($urandom_range(100)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
